min_sec_counter_ctrl: RTL and testbench



---
 rtl/min_sec_counter_ctrl.sv | 149 ++++++++++++++
 tb/tb_min_sec_counter_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/min_sec_counter_ctrl.sv
// Stopwatch control: run/pause/clear FSM, seconds.hundredths counter,
// and a four-digit multiplexed display scanner with an on/off toggle.
module min_sec_counter_ctrl #(
    parameter int P_TICK_DIV = 1_000_000,
    parameter int P_SCAN_DIV = 100_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run_btn,
    input  logic       i_clear_btn,
    input  logic       i_onoff_btn,
    input  logic [3:0] i_digit3,
    input  logic [3:0] i_digit2,
    input  logic [3:0] i_digit1,
    input  logic [3:0] i_digit0,
    output logic [5:0] o_sec,
    output logic [6:0] o_csec,
    output logic [3:0] o_digit_sel,
    output logic [3:0] o_digit_val,
    output logic       o_running
);

    localparam int TW = (P_TICK_DIV > 2) ? $clog2(P_TICK_DIV) : 1;
    localparam int SW = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(P_TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(P_SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [SW-1:0] scan_cnt;
    logic          scan_step;
    logic [1:0]    scan_idx;
    logic [1:0]    scan_idx_nxt;
    logic          disp_on;
    logic          disp_on_nxt;
    logic [3:0]    digit_mux;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear overrides any run/pause request in the same cycle.
    always_comb begin
        state_nxt = state;
        if (i_clear_btn) begin
            state_nxt = S_IDLE;
        end else if (i_run_btn) begin
            unique case (state)
                S_IDLE:  state_nxt = S_RUN;
                S_RUN:   state_nxt = S_PAUSE;
                S_PAUSE: state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign tick = (state == S_RUN) && (tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt <= '0;
        end else if (i_clear_btn) begin
            tick_cnt <= '0;
        end else if (state == S_RUN) begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sec  <= '0;
            o_csec <= '0;
        end else if (i_clear_btn) begin
            o_sec  <= '0;
            o_csec <= '0;
        end else if (tick) begin
            if (o_csec == 7'd99) begin
                o_csec <= '0;
                o_sec  <= (o_sec == 6'd59) ? 6'd0 : o_sec + 6'd1;
            end else begin
                o_csec <= o_csec + 7'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_running <= 1'b0;
        end else begin
            o_running <= (state_nxt == S_RUN);
        end
    end

    assign scan_step    = (scan_cnt == SCAN_LAST);
    assign scan_idx_nxt = scan_step ? scan_idx + 2'd1 : scan_idx;
    assign disp_on_nxt  = disp_on ^ i_onoff_btn;

    always_comb begin
        digit_mux = i_digit0;
        unique case (scan_idx_nxt)
            2'd0: digit_mux = i_digit0;
            2'd1: digit_mux = i_digit1;
            2'd2: digit_mux = i_digit2;
            2'd3: digit_mux = i_digit3;
            default: digit_mux = i_digit0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            disp_on  <= 1'b1;
        end else begin
            scan_cnt <= scan_step ? '0 : scan_cnt + SW'(1);
            scan_idx <= scan_idx_nxt;
            disp_on  <= disp_on_nxt;
        end
    end

    // Display outputs only move on a scan step or an on/off change.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_digit_sel <= 4'b1110;
            o_digit_val <= 4'd0;
        end else if (scan_step || i_onoff_btn) begin
            if (disp_on_nxt) begin
                o_digit_sel <= ~(4'b0001 << scan_idx_nxt);
                o_digit_val <= digit_mux;
            end else begin
                o_digit_sel <= 4'b1111;
                o_digit_val <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_min_sec_counter_ctrl.sv
// Directed bench for min_sec_counter_ctrl with P_TICK_DIV=4, P_SCAN_DIV=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_min_sec_counter_ctrl;

    logic       clk;
    logic       rst;
    logic       run_btn;
    logic       clear_btn;
    logic       onoff_btn;
    logic [3:0] d3, d2, d1, d0;
    logic [5:0] sec;
    logic [6:0] csec;
    logic [3:0] sel;
    logic [3:0] val;
    logic       running;

    int pass_cnt;
    int total_cnt;

    min_sec_counter_ctrl #(
        .P_TICK_DIV(4),
        .P_SCAN_DIV(2)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_run_btn(run_btn),
        .i_clear_btn(clear_btn),
        .i_onoff_btn(onoff_btn),
        .i_digit3(d3),
        .i_digit2(d2),
        .i_digit1(d1),
        .i_digit0(d0),
        .o_sec(sec),
        .o_csec(csec),
        .o_digit_sel(sel),
        .o_digit_val(val),
        .o_running(running)
    );

    always #5 clk = ~clk;

    task automatic pulse_run();
        run_btn = 1'b1;
        @(negedge clk);
        run_btn = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_btn = 1'b1;
        @(negedge clk);
        clear_btn = 1'b0;
    endtask

    task automatic pulse_onoff();
        onoff_btn = 1'b1;
        @(negedge clk);
        onoff_btn = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if (sec !== 6'd0) $display("FAIL reset_sec got %0d want 0", sec);
        else pass_cnt++;
        total_cnt++;
        if (csec !== 7'd0) $display("FAIL reset_csec got %0d want 0", csec);
        else pass_cnt++;
        total_cnt++;
        if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running);
        else pass_cnt++;
        total_cnt++;
        if (sel !== 4'b1110) $display("FAIL reset_sel got %b want 1110", sel);
        else pass_cnt++;
        total_cnt++;
        if (val !== 4'd0) $display("FAIL reset_val got %0d want 0", val);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_run_wrap();
        pulse_run();
        repeat (4) @(negedge clk);
        total_cnt++;
        if (csec !== 7'd1) $display("FAIL first_tick_csec got %0d want 1", csec);
        else pass_cnt++;
        repeat (396) @(negedge clk);
        total_cnt++;
        if (sec !== 6'd1 || csec !== 7'd0)
            $display("FAIL run400 got %0d:%0d want 1:0", sec, csec);
        else pass_cnt++;
        total_cnt++;
        if (running !== 1'b1) $display("FAIL run400_running got %b want 1", running);
        else pass_cnt++;
    endtask

    task automatic test_clear_run();
        clear_btn = 1'b1;
        run_btn   = 1'b1;
        @(negedge clk);
        clear_btn = 1'b0;
        run_btn   = 1'b0;
        total_cnt++;
        if (sec !== 6'd0 || csec !== 7'd0 || running !== 1'b0)
            $display("FAIL clear_run got %0d:%0d run=%b want 0:0 run=0",
                     sec, csec, running);
        else pass_cnt++;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (csec !== 7'd0) $display("FAIL idle_hold_csec got %0d want 0", csec);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        pulse_clear();
        pulse_run();
        repeat (10) @(negedge clk);
        total_cnt++;
        if (csec !== 7'd2) $display("FAIL pre_pause_csec got %0d want 2", csec);
        else pass_cnt++;
        pulse_run();
        total_cnt++;
        if (running !== 1'b0) $display("FAIL pause_running got %b want 0", running);
        else pass_cnt++;
        repeat (50) @(negedge clk);
        total_cnt++;
        if (csec !== 7'd2) $display("FAIL paused_csec got %0d want 2", csec);
        else pass_cnt++;
        pulse_run();
        total_cnt++;
        if (running !== 1'b1 || csec !== 7'd2)
            $display("FAIL resume got csec=%0d run=%b want csec=2 run=1",
                     csec, running);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (csec !== 7'd3) $display("FAIL resume_phase_csec got %0d want 3", csec);
        else pass_cnt++;
    endtask

    task automatic test_wrap_5999();
        pulse_clear();
        pulse_run();
        repeat (4 * 5999) @(negedge clk);
        total_cnt++;
        if (sec !== 6'd59 || csec !== 7'd99)
            $display("FAIL preload got %0d:%0d want 59:99", sec, csec);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (sec !== 6'd0 || csec !== 7'd0 || running !== 1'b1)
            $display("FAIL full_wrap got %0d:%0d run=%b want 0:0 run=1",
                     sec, csec, running);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        repeat (21) @(negedge clk);
        total_cnt++;
        if (csec !== 7'd5) $display("FAIL pre_reset_csec got %0d want 5", csec);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (sec !== 6'd0 || csec !== 7'd0 || running !== 1'b0)
            $display("FAIL async_reset got %0d:%0d run=%b want 0:0 run=0",
                     sec, csec, running);
        else pass_cnt++;
        total_cnt++;
        if (sel !== 4'b1110 || val !== 4'd0)
            $display("FAIL async_reset_disp got %b/%0d want 1110/0", sel, val);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (sel !== 4'b1101 || val !== 4'd3)
            $display("FAIL post_reset_scan got %b/%0d want 1101/3", sel, val);
        else pass_cnt++;
        total_cnt++;
        if (running !== 1'b0 || csec !== 7'd0)
            $display("FAIL post_reset_idle got csec=%0d run=%b want 0/0",
                     csec, running);
        else pass_cnt++;
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel [4];
        logic [3:0] exp_val [4];
        exp_sel = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_val = '{4'd3, 4'd2, 4'd1, 4'd4};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (sel !== 4'b1110 || val !== 4'd0)
            $display("FAIL scan_start got %b/%0d want 1110/0", sel, val);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (i > 0 && (sel !== exp_sel[i-1] || val !== exp_val[i-1]))
                $display("FAIL scan_hold%0d got %b/%0d want %b/%0d",
                         i, sel, val, exp_sel[i-1], exp_val[i-1]);
            else if (i == 0 && (sel !== 4'b1110 || val !== 4'd0))
                $display("FAIL scan_hold0 got %b/%0d want 1110/0", sel, val);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (sel !== exp_sel[i] || val !== exp_val[i])
                $display("FAIL scan_step%0d got %b/%0d want %b/%0d",
                         i, sel, val, exp_sel[i], exp_val[i]);
            else pass_cnt++;
        end
        pulse_onoff();
        total_cnt++;
        if (sel !== 4'b1111 || val !== 4'd0)
            $display("FAIL disp_off got %b/%0d want 1111/0", sel, val);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (sel !== 4'b1111 || val !== 4'd0)
            $display("FAIL disp_off_hold got %b/%0d want 1111/0", sel, val);
        else pass_cnt++;
        pulse_onoff();
        total_cnt++;
        if (sel !== 4'b0111 || val !== 4'd1)
            $display("FAIL disp_on got %b/%0d want 0111/1", sel, val);
        else pass_cnt++;
        onoff_btn = 1'b1;
        run_btn   = 1'b1;
        @(negedge clk);
        onoff_btn = 1'b0;
        run_btn   = 1'b0;
        total_cnt++;
        if (sel !== 4'b1111 || running !== 1'b1)
            $display("FAIL onoff_run got sel=%b run=%b want 1111/1",
                     sel, running);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (csec !== 7'd1)
            $display("FAIL count_disp_off got %0d want 1", csec);
        else pass_cnt++;
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        run_btn   = 1'b0;
        clear_btn = 1'b0;
        onoff_btn = 1'b0;
        d3        = 4'h1;
        d2        = 4'h2;
        d1        = 4'h3;
        d0        = 4'h4;
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_run_wrap();
        test_clear_run();
        test_pause();
        test_wrap_5999();
        test_async_reset();
        test_scan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
